// File: rtl/uncache_arbiter_pkg.sv
// Shared definitions for the uncached-access arbiter: FSM encoding and port ids.
package uncache_arbiter_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'b001,
      ST_WAIT = 3'b010,
      ST_RESP = 3'b100
   } arb_state_t;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/uncache_arb_pick.sv
// Combinational winner select between the instruction (m0) and data (m1) requesters.
module uncache_arb_pick
   import uncache_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b0
) (
   input  logic m0_req,
   input  logic m1_req,
   input  logic last,
   output logic grant,
   output logic valid
);

   always_comb begin
      valid = m0_req | m1_req;
      grant = ARB_M0;
      if (m0_req && m1_req) begin
         // Round-robin hands a tie to whichever port did not win last time.
         grant = RR_EN ? ~last : ARB_M1;
      end else if (m1_req) begin
         grant = ARB_M1;
      end
   end

endmodule

// File: rtl/uncache_arbiter.sv
// Two-master uncached-access arbiter: one outstanding downstream transaction at a time.
// Define UNCACHE_ARB_RR_EN for round-robin arbitration; default is fixed priority (m1 wins).
module uncache_arbiter
   import uncache_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_req,
   input  logic [3:0]  m0_wen,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_stallreq,

   input  logic        m1_req,
   input  logic [3:0]  m1_wen,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_stallreq,

   output logic        axi_en,
   output logic [3:0]  axi_wsel,
   output logic [31:0] axi_addr,
   output logic [31:0] axi_wdata,
   input  logic        reload,
   input  logic [31:0] axi_rdata,

   output logic        busy
);

   arb_state_t state, state_n;
   logic       grant_id;
   logic       last_grant;
   logic       win;
   logic       win_valid;
   logic       take;
   logic       done;

`ifdef UNCACHE_ARB_RR_EN
   localparam bit RR_EN = 1'b1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant <= ARB_M0;
      end else if (take) begin
         last_grant <= win;
      end
   end
`else
   localparam bit RR_EN = 1'b0;

   assign last_grant = ARB_M0;
`endif

   uncache_arb_pick #(
      .RR_EN (RR_EN)
   ) u_pick (
      .m0_req (m0_req),
      .m1_req (m1_req),
      .last   (last_grant),
      .grant  (win),
      .valid  (win_valid)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      take    = 1'b0;
      done    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (win_valid) begin
               take    = 1'b1;
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (reload) begin
               done    = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // The returned word lands straight in the granted port's rdata register,
   // which then holds it until that port's next completion.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         axi_en    <= 1'b0;
         axi_wsel  <= '0;
         axi_addr  <= '0;
         axi_wdata <= '0;
         grant_id  <= ARB_M0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else if (take) begin
         axi_en    <= 1'b1;
         axi_wsel  <= (win == ARB_M1) ? m1_wen   : m0_wen;
         axi_addr  <= (win == ARB_M1) ? m1_addr  : m0_addr;
         axi_wdata <= (win == ARB_M1) ? m1_wdata : m0_wdata;
         grant_id  <= win;
      end else if (done) begin
         axi_en    <= 1'b0;
         axi_wsel  <= '0;
         axi_addr  <= '0;
         axi_wdata <= '0;
         if (grant_id == ARB_M1) begin
            m1_rdata <= axi_rdata;
         end else begin
            m0_rdata <= axi_rdata;
         end
      end
   end

   assign m0_ack      = (state == ST_RESP) && (grant_id == ARB_M0);
   assign m1_ack      = (state == ST_RESP) && (grant_id == ARB_M1);
   assign m0_stallreq = m0_req & ~m0_ack;
   assign m1_stallreq = m1_req & ~m1_ack;
   assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uncache_arbiter.sv
// Directed self-checking bench for uncache_arbiter (fixed priority unless UNCACHE_ARB_RR_EN).
module tb_uncache_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_req, m1_req;
   logic [3:0]  m0_wen, m1_wen;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m1_ack, m0_stallreq, m1_stallreq;
   logic [31:0] m0_rdata, m1_rdata;
   logic        axi_en;
   logic [3:0]  axi_wsel;
   logic [31:0] axi_addr, axi_wdata;
   logic        reload;
   logic [31:0] axi_rdata;
   logic        busy;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   uncache_arbiter dut (
      .clk         (clk),
      .resetn      (resetn),
      .m0_req      (m0_req),
      .m0_wen      (m0_wen),
      .m0_addr     (m0_addr),
      .m0_wdata    (m0_wdata),
      .m0_ack      (m0_ack),
      .m0_rdata    (m0_rdata),
      .m0_stallreq (m0_stallreq),
      .m1_req      (m1_req),
      .m1_wen      (m1_wen),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_ack      (m1_ack),
      .m1_rdata    (m1_rdata),
      .m1_stallreq (m1_stallreq),
      .axi_en      (axi_en),
      .axi_wsel    (axi_wsel),
      .axi_addr    (axi_addr),
      .axi_wdata   (axi_wdata),
      .reload      (reload),
      .axi_rdata   (axi_rdata),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_addr;
      resetn    = 1'b0;
      m0_req    = 1'b0; m0_wen = '0; m0_addr = '0; m0_wdata = '0;
      m1_req    = 1'b0; m1_wen = '0; m1_addr = '0; m1_wdata = '0;
      reload    = 1'b0;
      axi_rdata = '0;
      tick(); tick();
      check("rst_axi_en", {31'd0, axi_en}, 32'd0);
      check("rst_busy",   {31'd0, busy}, 32'd0);
      check("rst_acks",   {30'd0, m0_ack, m1_ack}, 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      resetn = 1'b1;
      tick();

      // m1 read alone: req in cycle 0, reload in cycle 4, ack in cycle 5
      m1_req = 1'b1; m1_addr = 32'h1faf_fff0;
      tick();                                                  // cycle 1
      check("c1_axi_en",   {31'd0, axi_en}, 32'd1);
      check("c1_axi_addr", axi_addr, 32'h1faf_fff0);
      check("c1_axi_wsel", {28'd0, axi_wsel}, 32'd0);
      check("c1_busy",     {31'd0, busy}, 32'd1);
      tick(); tick(); tick();                                  // cycle 4
      check("c4_axi_en",   {31'd0, axi_en}, 32'd1);
      check("c4_stall",    {31'd0, m1_stallreq}, 32'd1);
      reload = 1'b1; axi_rdata = 32'hDEAD_BEEF;
      tick();                                                  // cycle 5
      reload = 1'b0; axi_rdata = '0;
      check("c5_m1_ack",   {31'd0, m1_ack}, 32'd1);
      check("c5_m0_ack",   {31'd0, m0_ack}, 32'd0);
      check("c5_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
      check("c5_axi_en",   {31'd0, axi_en}, 32'd0);
      check("c5_axi_addr", axi_addr, 32'd0);
      check("c5_stall",    {31'd0, m1_stallreq}, 32'd0);
      m1_req = 1'b0;
      tick();                                                  // cycle 6
      check("c6_m1_ack",   {31'd0, m1_ack}, 32'd0);
      check("c6_busy",     {31'd0, busy}, 32'd0);
      check("c6_rd_hold",  m1_rdata, 32'hDEAD_BEEF);

      // simultaneous reads, fixed priority in the default build
      m0_req = 1'b1; m0_addr = 32'h0000_0a00;
      m1_req = 1'b1; m1_addr = 32'h0000_0b00;
      tick();
`ifdef UNCACHE_ARB_RR_EN
      exp_addr = 32'h0000_0b00;    // pointer last granted m1 above -> m0 wins
      exp_addr = 32'h0000_0a00;
`else
      exp_addr = 32'h0000_0b00;
`endif
      check("both_first_addr", axi_addr, exp_addr);
      check("both_m0_stall",   {31'd0, m0_stallreq}, (exp_addr == 32'h0000_0b00) ? 32'd1 : 32'd0);
      tick();
      reload = 1'b1; axi_rdata = 32'h1111_0001;
      tick();                                                  // ack cycle A
      reload = 1'b0;
`ifndef UNCACHE_ARB_RR_EN
      check("both_m1_ack",   {31'd0, m1_ack}, 32'd1);
      check("both_m0_stall2", {31'd0, m0_stallreq}, 32'd1);
      m1_req = 1'b0;
      tick();                                                  // A+1
      check("both_a1_en",    {31'd0, axi_en}, 32'd0);
      check("both_a1_stall", {31'd0, m0_stallreq}, 32'd1);
      tick();                                                  // A+2
      check("both_a2_en",    {31'd0, axi_en}, 32'd1);
      check("both_a2_addr",  axi_addr, 32'h0000_0a00);
      reload = 1'b1; axi_rdata = 32'h2222_0002;
      tick();
      reload = 1'b0;
      check("both_m0_ack",   {31'd0, m0_ack}, 32'd1);
      check("both_m0_rdata", m0_rdata, 32'h2222_0002);
      check("both_m1_keep",  m1_rdata, 32'h1111_0001);
      m0_req = 1'b0;
`else
      check("both_m0_ack",   {31'd0, m0_ack}, 32'd1);
      m0_req = 1'b0;
      tick(); tick();
      check("both_m1_addr",  axi_addr, 32'h0000_0b00);
      reload = 1'b1; axi_rdata = 32'h2222_0002;
      tick();
      reload = 1'b0;
      check("both_m1_ack",   {31'd0, m1_ack}, 32'd1);
      m1_req = 1'b0;
      m0_req = 1'b0;
`endif
      tick();

      // m0 write
      m0_req = 1'b1; m0_wen = 4'hF; m0_addr = 32'h0000_0100; m0_wdata = 32'h1234_5678;
      tick();
      check("wr_wsel",  {28'd0, axi_wsel}, 32'h0000_000F);
      check("wr_wdata", axi_wdata, 32'h1234_5678);
      tick(); tick();
      check("wr_hold",  axi_wdata, 32'h1234_5678);
      reload = 1'b1; axi_rdata = 32'hCAFE_0001;
      tick();
      // reload held high into RESP must be ignored
      axi_rdata = 32'h9999_9999;
      check("wr_m0_ack",   {31'd0, m0_ack}, 32'd1);
      check("wr_m0_rdata", m0_rdata, 32'hCAFE_0001);
      check("wr_wsel0",    {28'd0, axi_wsel}, 32'd0);
      m0_req = 1'b0; m0_wen = '0;
      tick();
      reload = 1'b0;
      check("wr_ack_off",  {30'd0, m0_ack, m1_ack}, 32'd0);
      check("resp_reload_ign", m0_rdata, 32'hCAFE_0001);
      check("wr_busy",     {31'd0, busy}, 32'd0);

      // spurious reload in IDLE
      reload = 1'b1; axi_rdata = 32'h5555_5555;
      tick();
      reload = 1'b0;
      check("sp_busy",  {31'd0, busy}, 32'd0);
      check("sp_en",    {31'd0, axi_en}, 32'd0);
      check("sp_addr",  axi_addr, 32'd0);
      tick();
      check("sp_acks",  {30'd0, m0_ack, m1_ack}, 32'd0);
      check("sp_rdata", m0_rdata, 32'hCAFE_0001);

      // requester drops req before completion
      m1_req = 1'b1; m1_addr = 32'h0000_0c00;
      tick();
      m1_req = 1'b0;
      tick();
      check("drop_en", {31'd0, axi_en}, 32'd1);
      reload = 1'b1; axi_rdata = 32'h0D0D_0D0D;
      tick();
      reload = 1'b0;
      check("drop_ack",   {31'd0, m1_ack}, 32'd1);
      check("drop_rdata", m1_rdata, 32'h0D0D_0D0D);
      tick();
      check("drop_idle",  {31'd0, busy}, 32'd0);

      // reset during WAIT abandons the transaction
      m0_req = 1'b1; m0_addr = 32'h0000_0d00;
      tick();
      check("rw_en", {31'd0, axi_en}, 32'd1);
      resetn = 1'b0; m0_req = 1'b0;
      tick();
      resetn = 1'b1;
      reload = 1'b1; axi_rdata = 32'h7777_7777;
      tick();
      reload = 1'b0;
      check("rw_en0",   {31'd0, axi_en}, 32'd0);
      check("rw_busy",  {31'd0, busy}, 32'd0);
      check("rw_acks",  {30'd0, m0_ack, m1_ack}, 32'd0);
      check("rw_rd0",   m0_rdata, 32'd0);
      check("rw_rd1",   m1_rdata, 32'd0);
      check("rw_addr",  axi_addr, 32'd0);
      tick();
      check("rw_acks2", {30'd0, m0_ack, m1_ack}, 32'd0);

      // both requests held over four transactions (pointer fresh from reset)
      m0_req = 1'b1; m0_addr = 32'h0000_00a0;
      m1_req = 1'b1; m1_addr = 32'h0000_00b0;
      for (int i = 0; i < 4; i++) begin
`ifdef UNCACHE_ARB_RR_EN
         exp_addr = (i % 2 == 0) ? 32'h0000_00b0 : 32'h0000_00a0;
`else
         exp_addr = 32'h0000_00b0;
`endif
         tick();
         check($sformatf("seq%0d_addr", i), axi_addr, exp_addr);
         reload = 1'b1; axi_rdata = 32'h0000_1000 + i;
         tick();
         reload = 1'b0;
         check($sformatf("seq%0d_ack", i), {30'd0, m1_ack, m0_ack},
               (exp_addr == 32'h0000_00b0) ? 32'd2 : 32'd1);
         tick();
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uncache_arbiter.md
UNCACHE_ARBITER -- requirements
Module: uncache_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 m0_req  in  1  instruction-side uncached request; held until m0_ack.
REQ-004 m0_wen  in  4  byte write strobes; 0 = read.
REQ-005 m0_addr, m0_wdata  in  32 each  request address / write data, stable while m0_req.
REQ-006 m0_ack  out  1  one-cycle completion pulse.
REQ-007 m0_rdata  out  32  read data, valid when m0_ack.
REQ-008 m0_stallreq  out  1  m0_req & ~m0_ack (combinational).
REQ-009 m1_req, m1_wen, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_stallreq  as REQ-003..008, data side.
REQ-010 axi_en  out  1  downstream request, held high until reload.
REQ-011 axi_wsel  out  4; axi_addr, axi_wdata  out  32 each  granted request's fields, registered.
REQ-012 reload  in  1  downstream completion pulse; axi_rdata  in  32  valid with reload.
REQ-013 busy  out  1  high in any state except IDLE.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; one-hot, encoding in shared header.
REQ-015 IDLE, any req high: select winner, latch its wen/addr/wdata into axi_* and set axi_en=1 next cycle; record grant id; go WAIT.
REQ-016 IDLE, no req: axi_* stay zero; remain IDLE.
REQ-017 Default arbitration: fixed priority, m1 (data) beats m0.
REQ-018 WAIT, reload=1: zero axi_en/axi_wsel/axi_addr/axi_wdata; register axi_rdata; go RESP.
REQ-019 WAIT, reload=0: hold all axi_* unchanged.
REQ-020 RESP: pulse ack of recorded grant for exactly one cycle with its rdata = registered axi_rdata; go IDLE.
REQ-021 Latency: req at cycle 0 (IDLE) -> axi_en at cycle 1; reload at cycle N -> ack at N+1; next axi_en earliest N+3.
REQ-022 rdata of each port holds its last value between acks; writes also ack, rdata then = axi_rdata captured.
REQ-023 reload in IDLE or RESP: ignored, no state or output change.
REQ-024 Requester dropping req before ack: transaction still completes; ack still pulsed; no retry.
REQ-025 Both reqs in same IDLE cycle: only winner granted; loser keeps stallreq high and is granted in a later IDLE.
REQ-026 Never more than one outstanding downstream transaction; never both acks in one cycle.

Reset
REQ-027 resetn=0 at a clock edge: state IDLE, axi_en=0, axi_wsel=0, axi_addr=0, axi_wdata=0, m0/m1_ack=0, m0/m1_rdata=0, grant id=m0, round-robin pointer=m0, busy=0.
REQ-028 Reset mid-WAIT abandons the transaction; a reload arriving after reset is ignored per REQ-023.

Configuration
REQ-029 Macro UNCACHE_ARB_RR_EN defined: round-robin; on simultaneous reqs the port not granted last wins; pointer updates on each grant.
REQ-030 Macro undefined: fixed priority per REQ-017; no pointer register.

Structure
REQ-031 Shared header: FSM state encodings, state width, port-id constants (ARB_M0, ARB_M1).
REQ-032 One sub-module uncache_arb_pick: combinational winner select from two reqs plus pointer; both policies inside.

Verification
REQ-033 m1 read addr 0x1faf_fff0 alone; reload at cycle 4 with 0xDEADBEEF -> axi_en cycles 1-4, m1_ack cycle 5, m1_rdata=0xDEADBEEF.
REQ-034 m0 and m1 reads same cycle, fixed priority -> m1 served first; m0_stallreq high throughout; m0 axi_en at m1_ack cycle+2.
REQ-035 UNCACHE_ARB_RR_EN, both reqs held over four transactions -> grants alternate m1,m0,m1,m0.
REQ-036 m0 write wen=0xF, wdata=0x12345678 -> axi_wsel=0xF, axi_wdata=0x12345678 until reload; m0_ack one cycle.
REQ-037 Spurious reload in IDLE -> no ack, axi_* stay 0, state IDLE.
REQ-038 resetn low during WAIT, then reload -> all outputs zero, no ack, busy=0.
